bp_update: RTL
==============

Name: bp_update

Overview:
- Write-side companion to bp_cache. Accepts resolved-branch outcomes from execute and performs read-modify-write updates of the 2-bit saturating direction counters.
- Sits between the execute-stage branch resolution logic and the cache's write port (wa/din/we) plus one read port (ra/dout/hit).
- Buffers outcomes in a small FIFO.
- Forwards in-flight writes so back-to-back updates to the same PC never lose an increment.

Parameters:
- AWIDTH, 32, branch PC / cache address width
- CWIDTH, 2, saturating counter width; also the cache DWIDTH this block drives
- DEPTH, 4, outcome FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- upd_valid  in  1  resolved-branch outcome present
- upd_ready  out  1  FIFO can accept the outcome this cycle
- upd_pc  in  AWIDTH  PC of resolved branch
- upd_taken  in  1  actual direction, 1 = taken
- hold  in  1  freeze drain pipeline (cache write port claimed elsewhere)
- cache_ra  out  AWIDTH  read address to bp_cache read port
- cache_dout  in  CWIDTH  counter read from cache (combinational, same cycle)
- cache_hit  in  1  cache_dout valid for cache_ra (combinational, same cycle)
- cache_wa  out  AWIDTH  write address to bp_cache
- cache_din  out  CWIDTH  new counter value
- cache_we  out  1  write enable; cache captures on next rising edge
- busy  out  1  FIFO non-empty or any pipeline stage valid

Behaviour:
- Reset (sync, active-high): FIFO emptied; S1 and S2 valid cleared; wa=0, din=0, cache_ra=0.
  - cache_we=0 and busy=0 from the reset edge.
  - upd_ready=0 while reset is high, 1 on the first cycle after.
  - Reset mid-operation discards all queued and in-flight updates; no write from before reset ever appears afterwards.
- Accept: push when upd_valid && upd_ready at the edge.
  - upd_ready = !full && !reset; it does not depend on a same-cycle pop.
  - No bypass: an entry pushed into an empty FIFO is popped no earlier than the next edge.
- Pipeline, advancing only when hold=0:
  - Pop: FIFO head moves into S1 (pc, taken) when the FIFO is non-empty. S1 is cleared if the FIFO is empty.
  - S1, combinational:
    - cache_ra = S1.pc (holds last value when S1 is invalid).
    - Current counter source: if S2 valid and S2.wa == S1.pc (full-address compare), use S2.din with hit forced to 1 (forward). Otherwise use cache_dout/cache_hit.
  - Next-counter rule:
    - Miss, taken: 2^(CWIDTH-1) (weakly taken, 2'b10).
    - Miss, not-taken: 2^(CWIDTH-1)-1 (weakly not-taken, 2'b01).
    - Hit, taken: min(cur+1, 2^CWIDTH-1).
    - Hit, not-taken: max(cur-1, 0).
    - No wrap-around in either direction.
  - S2 register: captures S1 pc to wa and the next counter to din; S2 valid <= S1 valid.
- cache_we = S2 valid && !hold. wa/din are registered outputs.
- hold=1: no pop; S1 and S2 hold contents; cache_we=0. The held S2 write is presented again when hold drops. Pushes are still accepted up to DEPTH.
- Latency: accept at edge E0, S1 at E1, cache_we=1 during the cycle after E2. Cache commits at E3. Throughput is 1 update/cycle.
- busy = FIFO non-empty || S1 valid || S2 valid.

Test Plan:
1. Empty cache; push pc=0x10 taken -> cache_we=1, wa=0x10, din=2'b10 exactly two cycles after accept, for one cycle; busy falls the cycle after.
2. Preload 0x20=3 and 0x30=0; push 0x20 taken, then 0x30 not-taken -> din=3 then din=0 (saturation, no wrap).
3. Empty cache; push 0x40 taken on three consecutive cycles -> din 2, 3, 3 on three consecutive write cycles (forwarding from S2).
4. Mix: push 0x40 taken, 0x50 not-taken, 0x40 taken back-to-back; 0x40 preloaded to 1 -> writes 0x40=2, 0x50=2'b01, 0x40=3.
5. hold=1 from idle; push six outcomes -> first four accepted, upd_ready=0 afterwards, cache_we=0 throughout. Release hold -> four writes in accept order on consecutive cycles; upd_ready returns 1 the cycle after the first pop.
6. Three outcomes queued, one in S2; assert reset for one cycle -> cache_we=0, busy=0 the next cycle; upd_ready=1 after reset; no further writes occur.

Source files
------------

// File: rtl/bp_update_if.sv
// bp_update bus bundle: branch-outcome handshake plus the
// bp_cache read/write port signals driven or consumed by bp_update.
interface bp_update_if #(
    parameter int AWIDTH = 32,
    parameter int CWIDTH = 2
);
    logic              upd_valid;
    logic              upd_ready;
    logic [AWIDTH-1:0] upd_pc;
    logic              upd_taken;
    logic [AWIDTH-1:0] cache_ra;
    logic [CWIDTH-1:0] cache_dout;
    logic              cache_hit;
    logic [AWIDTH-1:0] cache_wa;
    logic [CWIDTH-1:0] cache_din;
    logic              cache_we;

    modport slave (
        input  upd_valid, upd_pc, upd_taken,
        input  cache_dout, cache_hit,
        output upd_ready,
        output cache_ra, cache_wa, cache_din, cache_we
    );

    modport master (
        output upd_valid, upd_pc, upd_taken,
        output cache_dout, cache_hit,
        input  upd_ready,
        input  cache_ra, cache_wa, cache_din, cache_we
    );
endinterface

// File: rtl/bp_update.sv
// bp_update: queues resolved-branch outcomes and performs
// read-modify-write of 2-bit direction counters in bp_cache.
module bp_update #(
    parameter int AWIDTH = 32,
    parameter int CWIDTH = 2,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    bp_update_if.slave bus,
    output logic       busy
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CWIDTH-1:0] CMAX = '1;
    localparam logic [CWIDTH-1:0] WT   = {1'b1, {(CWIDTH-1){1'b0}}};
    localparam logic [CWIDTH-1:0] WNT  = {1'b0, {(CWIDTH-1){1'b1}}};

    logic [AWIDTH-1:0] fifo_pc_q [DEPTH];
    logic              fifo_tk_q [DEPTH];
    logic [PW:0]       wptr_q, rptr_q;
    logic              empty, full, push, pop;

    logic              s1_v_q, s1_tk_q;
    logic [AWIDTH-1:0] s1_pc_q;
    logic              s1_v_d, s1_tk_d;
    logic [AWIDTH-1:0] s1_pc_d;

    logic              s2_v_q;
    logic [AWIDTH-1:0] wa_q;
    logic [CWIDTH-1:0] din_q;
    logic              s2_v_d;
    logic [AWIDTH-1:0] wa_d;
    logic [CWIDTH-1:0] din_d;

    logic              fwd, cur_hit;
    logic [CWIDTH-1:0] cur, nxt;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW] != rptr_q[PW]) &&
                   (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign push  = bus.upd_valid && bus.upd_ready;
    assign pop   = !hold && !empty;

    assign bus.upd_ready = !full && !reset;

    // S2 still holds an uncommitted write; forward it on a PC match
    assign fwd     = s2_v_q && (wa_q == s1_pc_q);
    assign cur     = fwd ? din_q : bus.cache_dout;
    assign cur_hit = fwd || bus.cache_hit;

    // Saturating counter update; misses seed a weak state
    always_comb begin
        nxt = '0;
        if (!cur_hit) begin
            nxt = s1_tk_q ? WT : WNT;
        end else if (s1_tk_q) begin
            nxt = (cur == CMAX) ? cur : cur + CWIDTH'(1);
        end else begin
            nxt = (cur == '0) ? cur : cur - CWIDTH'(1);
        end
    end

    // Pipeline advance: pop into S1, S1 result into S2, frozen on hold
    always_comb begin
        s1_v_d  = s1_v_q;
        s1_pc_d = s1_pc_q;
        s1_tk_d = s1_tk_q;
        s2_v_d  = s2_v_q;
        wa_d    = wa_q;
        din_d   = din_q;
        if (!hold) begin
            s1_v_d = !empty;
            if (!empty) begin
                s1_pc_d = fifo_pc_q[rptr_q[PW-1:0]];
                s1_tk_d = fifo_tk_q[rptr_q[PW-1:0]];
            end
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                wa_d  = s1_pc_q;
                din_d = nxt;
            end
        end
    end

    // Outcome FIFO: storage written on accept, pointers cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (PW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (PW+1)'(1);
        end
        if (push) begin
            fifo_pc_q[wptr_q[PW-1:0]] <= bus.upd_pc;
            fifo_tk_q[wptr_q[PW-1:0]] <= bus.upd_taken;
        end
    end

    // S1/S2 stage registers; reset drops every in-flight update
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q  <= 1'b0;
            s1_pc_q <= '0;
            s1_tk_q <= 1'b0;
            s2_v_q  <= 1'b0;
            wa_q    <= '0;
            din_q   <= '0;
        end else begin
            s1_v_q  <= s1_v_d;
            s1_pc_q <= s1_pc_d;
            s1_tk_q <= s1_tk_d;
            s2_v_q  <= s2_v_d;
            wa_q    <= wa_d;
            din_q   <= din_d;
        end
    end

    assign bus.cache_ra  = s1_pc_q;
    assign bus.cache_wa  = wa_q;
    assign bus.cache_din = din_q;
    assign bus.cache_we  = s2_v_q && !hold;

    assign busy = !empty || s1_v_q || s2_v_q;
endmodule
